// File: rtl/seq_nibble_subtractor.sv
// Multi-cycle wide subtractor: one 4-bit borrow-lookahead stage, one nibble per clock, LSB first.
// Latency: start sampled at edge t, done pulses in the cycle after edge t+NIBBLES.
// Backpressure: no queueing; start is ignored while busy (RUN/DONE) and re-sampled in IDLE.
module seq_nibble_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  input  logic                   i_bin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_diff,
  output logic                   o_bout,
  output logic                   o_zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_br;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_diff;
  logic            r_bout;
  logic            r_zero;

  logic [3:0]      w_x;
  logic [3:0]      w_y;
  logic [3:0]      w_g;
  logic [3:0]      w_p;
  logic [3:0]      w_bc;
  logic [3:0]      w_diff;
  logic            w_bout;
  logic [W-1:0]    w_res_next;
  logic            w_last;

  assign w_x    = r_a[3:0];
  assign w_y    = r_b[3:0];
  assign w_last = (r_cnt == LAST);

  // 4-bit borrow-lookahead stage: generate when x<y, propagate the incoming borrow when x==y
  always_comb begin
    w_g     = ~w_x & w_y;
    w_p     = ~(w_x ^ w_y);
    w_bc[0] = r_br;
    w_bc[1] = w_g[0] | (w_p[0] & r_br);
    w_bc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_br);
    w_bc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & r_br);
    w_bout  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_br);
    w_diff  = w_x ^ w_y ^ w_bc;
  end

  // New nibble enters the result register from the top; a single nibble needs no shift
  generate
    if (NIBBLES == 1) begin : g_one
      assign w_res_next = w_diff;
    end else begin : g_many
      assign w_res_next = {w_diff, r_res[W-1:4]};
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, nibble-serial datapath and result load on the final nibble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_br  <= i_bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 4;
          r_b   <= r_b >> 4;
          r_br  <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          r_res <= w_res_next;
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bout;
            r_zero <= (w_res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_diff = r_diff;
  assign o_bout = r_bout;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_seq_nibble_subtractor.sv
// Bench for seq_nibble_subtractor at NIBBLES=1, 4 and 8.
// Drivers push expected results with their due cycle; per-instance monitors pop and compare on done.
// Directed vectors exercise NIBBLES=4, then random sweeps run on all three instances in parallel.
module tb_seq_nibble_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  bit   prev_dn [3];

  logic        s1_start, s1_bin, s1_busy, s1_done, s1_bout, s1_zero;
  logic [3:0]  s1_a, s1_b, s1_diff;
  logic        s4_start, s4_bin, s4_busy, s4_done, s4_bout, s4_zero;
  logic [15:0] s4_a, s4_b, s4_diff;
  logic        s8_start, s8_bin, s8_busy, s8_done, s8_bout, s8_zero;
  logic [31:0] s8_a, s8_b, s8_diff;

  seq_nibble_subtractor #(.NIBBLES(1)) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1_start), .i_a(s1_a), .i_b(s1_b), .i_bin(s1_bin),
    .o_busy(s1_busy), .o_done(s1_done), .o_diff(s1_diff), .o_bout(s1_bout), .o_zero(s1_zero)
  );
  seq_nibble_subtractor #(.NIBBLES(4)) u_n4 (
    .i_clk(clk), .i_rst(rst), .i_start(s4_start), .i_a(s4_a), .i_b(s4_b), .i_bin(s4_bin),
    .o_busy(s4_busy), .o_done(s4_done), .o_diff(s4_diff), .o_bout(s4_bout), .o_zero(s4_zero)
  );
  seq_nibble_subtractor #(.NIBBLES(8)) u_n8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_a(s8_a), .i_b(s8_b), .i_bin(s8_bin),
    .o_busy(s8_busy), .o_done(s8_done), .o_diff(s8_diff), .o_bout(s8_bout), .o_zero(s8_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pop and compare one expected result whenever an instance raises done
  task automatic mon(input int n, input int idx, input logic dn, input logic [31:0] d,
                     input logic bo, input logic z);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (dn) begin
      if (prev_dn[idx]) begin
        checks++;
        failures++;
        $display("FAIL done_width n=%0d done high two cycles in a row", n);
      end
      case (n)
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        4: if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
        default: if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done n=%0d diff=%h bout=%b (no request pending)", n, d, bo);
      end else begin
        chk($sformatf("diff_n%0d", n), d, e.diff);
        chk($sformatf("bout_n%0d", n), {31'd0, bo}, {31'd0, e.bout});
        chk($sformatf("zero_n%0d", n), {31'd0, z}, {31'd0, e.zero});
        chk($sformatf("latency_n%0d", n), cyc, e.cyc);
      end
    end
    prev_dn[idx] = dn;
  endtask

  always @(negedge clk) begin
    mon(1, 0, s1_done, {28'd0, s1_diff}, s1_bout, s1_zero);
    mon(4, 1, s4_done, {16'd0, s4_diff}, s4_bout, s4_zero);
    mon(8, 2, s8_done, s8_diff, s8_bout, s8_zero);
  end

  // Issue one accepted request to instance n and queue its expected result
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] ediff, input logic ebout);
    exp_t e;
    @(negedge clk);
    case (n)
      1: begin s1_a = a[3:0];  s1_b = b[3:0];  s1_bin = bin; s1_start = 1'b1; end
      4: begin s4_a = a[15:0]; s4_b = b[15:0]; s4_bin = bin; s4_start = 1'b1; end
      default: begin s8_a = a; s8_b = b; s8_bin = bin; s8_start = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    case (n)
      1: begin s1_start = 1'b0; s1_a = ~s1_a; s1_b = ~s1_b; s1_bin = ~s1_bin; end
      4: begin s4_start = 1'b0; s4_a = ~s4_a; s4_b = ~s4_b; s4_bin = ~s4_bin; end
      default: begin s8_start = 1'b0; s8_a = ~s8_a; s8_b = ~s8_b; s8_bin = ~s8_bin; end
    endcase
    e.diff = ediff;
    e.bout = ebout;
    e.zero = (ediff == 32'd0);
    e.cyc  = cyc + n;
    case (n)
      1: q1.push_back(e);
      4: q4.push_back(e);
      default: q8.push_back(e);
    endcase
    repeat (n + 1) @(posedge clk);
  endtask

  task automatic sweep(input int n, input int count);
    logic [31:0] a, b, m, ed;
    logic [32:0] full;
    logic        bin;
    m = (n == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * n)) - 32'd1);
    for (int i = 0; i < count; i++) begin
      a   = $urandom & m;
      b   = $urandom & m;
      bin = 1'($urandom_range(0, 1));
      if (i % 50 == 0) b = a;
      full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      ed   = full[31:0] & m;
      issue(n, a, b, bin, ed, full[4 * n]);
    end
  endtask

  initial begin
    int left;
    cyc = 0; checks = 0; failures = 0;
    s1_start = 0; s1_a = '0; s1_b = '0; s1_bin = 0;
    s4_start = 0; s4_a = '0; s4_b = '0; s4_bin = 0;
    s8_start = 0; s8_a = '0; s8_b = '0; s8_bin = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, s4_busy}, 32'd0);
    chk("rst_done", {31'd0, s4_done}, 32'd0);
    chk("rst_diff", {16'd0, s4_diff}, 32'd0);
    chk("rst_bout", {31'd0, s4_bout}, 32'd0);
    chk("rst_zero", {31'd0, s4_zero}, 32'd0);
    chk("rst_busy_n8", {31'd0, s8_busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors at NIBBLES=4
    issue(4, 32'h1234, 32'h0235, 1'b0, 32'h0FFF, 1'b0);
    issue(4, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1);
    issue(4, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1);
    issue(4, 32'hFFFF, 32'hFFFF, 1'b0, 32'h0000, 1'b0);
    issue(4, 32'h0010, 32'h0000, 1'b1, 32'h000F, 1'b0);
    issue(4, 32'h0005, 32'h0003, 1'b1, 32'h0001, 1'b0);

    // start held high through RUN and DONE with other operands: must be ignored
    fork
      issue(4, 32'hA5A5, 32'h5A5A, 1'b0, 32'h4B4B, 1'b0);
      begin
        repeat (2) @(negedge clk);
        s4_start = 1'b1; s4_a = 16'h0000; s4_b = 16'h1111; s4_bin = 1'b1;
        repeat (4) @(negedge clk);
        s4_start = 1'b0;
      end
    join
    @(negedge clk);
    chk("busy_not_extended", {31'd0, s4_busy}, 32'd0);
    chk("hold_diff_idle", {16'd0, s4_diff}, 32'h4B4B);

    // Reset during the second RUN cycle aborts without a done pulse
    @(negedge clk);
    s4_a = 16'h1111; s4_b = 16'h0001; s4_bin = 1'b0; s4_start = 1'b1;
    @(posedge clk);
    #1 s4_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_run", {31'd0, s4_busy}, 32'd1);
    chk("hold_diff_run", {16'd0, s4_diff}, 32'h4B4B);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, s4_busy}, 32'd0);
    chk("abort_done", {31'd0, s4_done}, 32'd0);
    chk("abort_diff", {16'd0, s4_diff}, 32'd0);
    chk("abort_bout", {31'd0, s4_bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(4, 32'h8000, 32'h0001, 1'b1, 32'h7FFE, 1'b0);

    // Random sweeps, all widths in parallel
    fork
      sweep(1, 1000);
      sweep(4, 1000);
      sweep(8, 1000);
    join

    for (int i = 0; i < 200 && (q1.size() + q4.size() + q8.size()) > 0; i++) @(negedge clk);
    left = q1.size() + q4.size() + q8.size();
    if (left > 0) begin
      checks++;
      failures++;
      $display("FAIL missing_done outstanding=%0d expected=0", left);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
